// File: rtl/wb_slave_ram_if.sv
// Wishbone classic bus bundle for wb_slave_ram: master drives the request, slave
// returns data and the ACK/ERR termination.
interface wb_slave_ram_if #(
   parameter int DATA_W = 32,
   parameter int ADR_W  = 16
);
   logic                  CYC_I;
   logic                  STB_I;
   logic                  WE_I;
   logic [ADR_W-1:0]      ADR_I;
   logic [DATA_W/8-1:0]   SEL_I;
   logic [DATA_W-1:0]     DAT_I;
   logic [DATA_W-1:0]     DAT_O;
   logic                  ACK_O;
   logic                  ERR_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      input  DAT_O, ACK_O, ERR_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      output DAT_O, ACK_O, ERR_O
   );
endinterface

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave: DEPTH-word byte-writable RAM window plus two read-only
// ID words, with programmable wait states and ERR termination on bad accesses.
module wb_slave_ram #(
   parameter int                DATA_W      = 32,
   parameter int                ADR_W       = 16,
   parameter int                DEPTH       = 8,
   parameter logic [ADR_W-1:0]  BASE_ADR    = 'h0000,
   parameter logic [ADR_W-1:0]  ID_ADR      = 'h400A,
   parameter logic [DATA_W-1:0] ID0_VAL     = 'hABCD,
   parameter logic [DATA_W-1:0] ID1_VAL     = 'h1234,
   parameter int                WAIT_STATES = 0
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   wb_slave_ram_if.slave wb
);

   localparam int               SEL_W   = DATA_W / 8;
   localparam int               AW      = $clog2(DEPTH);
   localparam logic [ADR_W-1:0] ID1_ADR = ID_ADR + 1'b1;
   localparam logic [3:0]       WS      = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic                ack_r;
   logic                err_r;
   logic [DATA_W-1:0]   dat_o_r;

   logic [ADR_W-1:0]    adr_q;
   logic                we_q;
   logic [SEL_W-1:0]    sel_q;
   logic [DATA_W-1:0]   dat_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                req;
   logic [ADR_W-1:0]    a_adr;
   logic                a_we;
   logic [SEL_W-1:0]    a_sel;
   logic [DATA_W-1:0]   a_dat;
   logic                ram_hit;
   logic                id_hit;
   logic                acc_err;
   logic                do_access;
   logic                ram_we;
   logic [AW-1:0]       idx;
   logic [DATA_W-1:0]   rd_word;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [SEL_W-1:0]  sel
   );
      logic [DATA_W-1:0] m;
      m = old_w;
      for (int i = 0; i < SEL_W; i++)
         if (sel[i]) m[8*i +: 8] = new_w[8*i +: 8];
      return m;
   endfunction

   assign req = wb.CYC_I & wb.STB_I;

   // With zero wait states the access happens on the accepting edge, so decode the live bus.
   always_comb begin
      a_adr = adr_q;
      a_we  = we_q;
      a_sel = sel_q;
      a_dat = dat_q;
      if (state == IDLE) begin
         a_adr = wb.ADR_I;
         a_we  = wb.WE_I;
         a_sel = wb.SEL_I;
         a_dat = wb.DAT_I;
      end
   end

   assign ram_hit   = (a_adr[ADR_W-1:AW] == BASE_ADR[ADR_W-1:AW]);
   assign id_hit    = (a_adr == ID_ADR) || (a_adr == ID1_ADR);
   assign acc_err   = !ram_hit && (!id_hit || a_we);
   assign idx       = a_adr[AW-1:0];
   assign do_access = !RST_I && req &&
                      (((state == IDLE) && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1)));
   assign ram_we    = do_access && ram_hit && a_we;
   assign rd_word   = ram_hit ? mem[idx] : ((a_adr == ID_ADR) ? ID0_VAL : ID1_VAL);

   always_ff @(posedge CLK_I) begin
      if ((state == IDLE) && req) begin
         adr_q <= wb.ADR_I;
         we_q  <= wb.WE_I;
         sel_q <= wb.SEL_I;
         dat_q <= wb.DAT_I;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (ram_we) mem[idx] <= merge_bytes(mem[idx], a_dat, a_sel);
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state   <= IDLE;
         cnt     <= '0;
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         dat_o_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (WS == 4'd0) begin
                     state <= RESP;
                  end else begin
                     cnt   <= WS;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == 4'd1) begin
                  cnt   <= '0;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (!req) begin
                  ack_r <= 1'b0;
                  err_r <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_access) begin
            if (acc_err) begin
               err_r <= 1'b1;
            end else begin
               ack_r <= 1'b1;
               if (!a_we) dat_o_r <= rd_word;
            end
         end
      end
   end

   assign wb.DAT_O = dat_o_r;
   assign wb.ACK_O = ack_r & req;
   assign wb.ERR_O = err_r & req;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed scoreboard bench for wb_slave_ram: one instance with no wait states and
// one with three, sharing a stimulus bus steered by dsel.
module tb_wb_slave_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we, dsel;
   logic [15:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat;
   logic        ack, err;
   logic [31:0] dat_o;

   int checks = 0;
   int errors = 0;
   int cur_ws = 0;

   typedef struct {
      string       tag;
      bit          is_err;
      logic [31:0] data;
   } sb_t;
   sb_t sb[$];

   always #5 clk = ~clk;

   wb_slave_ram_if #(.DATA_W(32), .ADR_W(16)) if0 ();
   wb_slave_ram_if #(.DATA_W(32), .ADR_W(16)) if3 ();

   assign if0.CYC_I = cyc & ~dsel;
   assign if0.STB_I = stb & ~dsel;
   assign if0.WE_I  = we;
   assign if0.ADR_I = adr;
   assign if0.SEL_I = sel;
   assign if0.DAT_I = dat;
   assign if3.CYC_I = cyc & dsel;
   assign if3.STB_I = stb & dsel;
   assign if3.WE_I  = we;
   assign if3.ADR_I = adr;
   assign if3.SEL_I = sel;
   assign if3.DAT_I = dat;

   assign ack   = dsel ? if3.ACK_O : if0.ACK_O;
   assign err   = dsel ? if3.ERR_O : if0.ERR_O;
   assign dat_o = dsel ? if3.DAT_O : if0.DAT_O;

   wb_slave_ram #(.WAIT_STATES(0)) dut0 (.CLK_I(clk), .RST_I(rst), .wb(if0));
   wb_slave_ram #(.WAIT_STATES(3)) dut3 (.CLK_I(clk), .RST_I(rst), .wb(if3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transfer: push expectation, drive, wait for termination, pop and compare.
   task automatic xfer(input string tag, input bit w, input logic [15:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input bit exp_err, input logic [31:0] exp_d, input int hold);
      sb_t e;
      int  n;
      e.tag = tag; e.is_err = exp_err; e.data = exp_d;
      sb.push_back(e);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack || err) && n < 20);
      e = sb.pop_front();
      check({e.tag, "_lat"}, 32'(n), 32'(cur_ws + 1));
      check({e.tag, "_ack"}, 32'(ack), 32'(!e.is_err));
      check({e.tag, "_err"}, 32'(err), 32'(e.is_err));
      check({e.tag, "_dat"}, dat_o, e.data);
      for (int i = 0; i < hold; i++) begin
         if (i == 0) dat = dat + 32'd1;
         @(negedge clk);
         check({e.tag, "_hold_ack"}, 32'(ack), 32'(!e.is_err));
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check({e.tag, "_idle_ack"}, 32'(ack | err), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; dsel = 1'b0;
      adr = '0; sel = '0; dat = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst0_ack", 32'(ack), 32'd0);
      check("rst0_err", 32'(err), 32'd0);
      check("rst0_dat", dat_o, 32'd0);
      dsel = 1'b1; #1;
      check("rst3_dat", dat_o, 32'd0);
      dsel = 1'b0;
      @(negedge clk);

      // No wait states
      cur_ws = 0;
      xfer("id0",      1'b0, 16'h400A, 4'hF, 32'h0,        1'b0, 32'h0000ABCD, 0);
      xfer("id1",      1'b0, 16'h400B, 4'hF, 32'h0,        1'b0, 32'h00001234, 0);
      xfer("wr3_full", 1'b1, 16'h0003, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00001234, 0);
      xfer("wr3_b0",   1'b1, 16'h0003, 4'h1, 32'h00000055, 1'b0, 32'h00001234, 0);
      xfer("rd3",      1'b0, 16'h0003, 4'h0, 32'h0,        1'b0, 32'hDEADBE55, 0);
      xfer("wr3_sel0", 1'b1, 16'h0003, 4'h0, 32'hFFFFFFFF, 1'b0, 32'hDEADBE55, 0);
      xfer("wr7",      1'b1, 16'h0007, 4'hF, 32'h0BADF00D, 1'b0, 32'hDEADBE55, 0);
      xfer("rd7",      1'b0, 16'h0007, 4'h2, 32'h0,        1'b0, 32'h0BADF00D, 0);
      xfer("rd3_again",1'b0, 16'h0003, 4'hF, 32'h0,        1'b0, 32'hDEADBE55, 0);
      xfer("miss_rd",  1'b0, 16'h0100, 4'hF, 32'h0,        1'b1, 32'hDEADBE55, 0);
      xfer("miss_end", 1'b0, 16'h0008, 4'hF, 32'h0,        1'b1, 32'hDEADBE55, 0);
      xfer("id0_wr",   1'b1, 16'h400A, 4'hF, 32'h11111111, 1'b1, 32'hDEADBE55, 0);
      xfer("id1_wr",   1'b1, 16'h400B, 4'hF, 32'h22222222, 1'b1, 32'hDEADBE55, 0);
      xfer("rd3_post", 1'b0, 16'h0003, 4'hF, 32'h0,        1'b0, 32'hDEADBE55, 0);
      xfer("wr0_hold", 1'b1, 16'h0000, 4'hF, 32'h00000001, 1'b0, 32'hDEADBE55, 5);
      xfer("rd0_hold", 1'b0, 16'h0000, 4'hF, 32'h0,        1'b0, 32'h00000001, 0);
      xfer("err_hold", 1'b0, 16'h0200, 4'hF, 32'h0,        1'b1, 32'h00000001, 2);

      // Three wait states
      dsel = 1'b1; cur_ws = 3;
      @(negedge clk);
      xfer("ws_wr0",   1'b1, 16'h0000, 4'hF, 32'h11112222, 1'b0, 32'h00000000, 0);
      xfer("ws_rd0",   1'b0, 16'h0000, 4'hF, 32'h0,        1'b0, 32'h11112222, 0);

      // Abandon a write two cycles into the wait
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0000; sel = 4'hF; dat = 32'hFFFFFFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("abort_wait_ack", 32'(ack | err), 32'd0);
      end
      stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_idle_ack", 32'(ack | err), 32'd0);
      end
      cyc = 1'b0;
      @(negedge clk);
      xfer("ws_rd_abort", 1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, 32'h11112222, 0);

      // Reset while a write is waiting
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0000; sel = 4'hF; dat = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstw_ack", 32'(ack), 32'd0);
      check("rstw_err", 32'(err), 32'd0);
      check("rstw_dat", dat_o, 32'd0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (4) @(negedge clk);
      xfer("ws_rd_rst", 1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, 32'h11112222, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_slave_ram.md
Name: wb_slave_ram

Overview:
- Parametrised Wishbone classic slave: DEPTH-word read/write RAM window plus two read-only ID words.
- Sits on the DSP controller's Wishbone bus beside the other slaves and serves as general scratch/config storage for the master.
- Adds byte-lane selects, programmable wait states, CYC_I qualification and error termination (ERR_O) for unmapped or illegal accesses.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8
ADR_W, 16, address bus width (word addresses)
DEPTH, 8, RAM words; power of 2, at least 2
BASE_ADR, 'h0000, word address of RAM word 0; aligned to DEPTH
ID_ADR, 'h400A, word address of ID0; ID1 is at ID_ADR+1
ID0_VAL, 'hABCD, read value of ID0, zero-extended to DATA_W
ID1_VAL, 'h1234, read value of ID1, zero-extended to DATA_W
WAIT_STATES, 0, extra cycles inserted before termination, 0..15

Ports:
CLK_I  in  1  clock; all logic on rising edge
RST_I  in  1  synchronous active-high reset
CYC_I  in  1  bus cycle valid
STB_I  in  1  strobe / data phase valid
WE_I  in  1  1 = write, 0 = read
ADR_I  in  ADR_W  word address
SEL_I  in  DATA_W/8  byte-lane enables; bit i covers DAT bits 8i+7..8i
DAT_I  in  DATA_W  write data
DAT_O  out  DATA_W  read data, registered
ACK_O  out  1  normal termination
ERR_O  out  1  error termination

Behaviour:
- Reset: state IDLE; ack_r=0, err_r=0, DAT_O=0, wait counter=0. RAM contents are not cleared.
- Decode uses the address latched in IDLE.
  - RAM hit: BASE_ADR <= adr < BASE_ADR+DEPTH; index = adr - BASE_ADR.
  - ID hit: adr = ID_ADR or ID_ADR+1.
  - Anything else is a miss.
- Error cases: a miss, or a write to an ID word, ends with ERR instead of ACK. RAM and DAT_O are untouched.
- Output gating:
  - ACK_O = ack_r & CYC_I & STB_I.
  - ERR_O = err_r & CYC_I & STB_I.
  - ACK_O and ERR_O are never high together.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Leaves only when CYC_I & STB_I.
  - On that edge, latches ADR_I, WE_I, SEL_I, DAT_I.
  - WAIT_STATES=0: go to RESP and perform the access on the same edge.
  - Otherwise: counter=WAIT_STATES, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter is 1: perform the access and go to RESP.
  - If CYC_I or STB_I is low at any edge: go to IDLE with no access committed.
- Access (the single edge that enters RESP):
  - Read hit: DAT_O <= word; ack_r <= 1.
  - Write hit: only bytes with SEL bit = 1 are written; ack_r <= 1; DAT_O holds its previous value.
  - SEL_I = 0 on a write: ack, RAM unchanged.
  - Error: err_r <= 1.
- RESP:
  - Holds ack_r/err_r and DAT_O stable while STB_I stays high.
  - When STB_I or CYC_I is low at an edge: clear ack_r/err_r, go to IDLE.
  - A new request is accepted from IDLE on the following edge at the earliest. No back-to-back acceptance in RESP.
- Latency: request sampled at edge k; the termination signal is visible after edge k+WAIT_STATES (1+WAIT_STATES cycles). Minimum transfer is 2 cycles including the return to IDLE.
- Write timing: memory is committed exactly once per transfer, at the access edge. Holding STB_I in RESP does not rewrite.
- Read data: full word returned regardless of SEL_I.
- RST_I asserted in any state: reset values on that edge. An access not yet committed is dropped; committed writes persist.
- Inputs: ADR_I/DAT_I/SEL_I changes after latching have no effect.

Test Plan:
- Reset, then read ADR=ID_ADR and ADR=ID_ADR+1 -> ACK_O one cycle after STB_I; DAT_O='hABCD, then 'h1234; ERR_O stays 0.
- Write 'hDEADBEEF to BASE_ADR+3 (SEL='hF), then write 'h00000055 to the same word with SEL='b0001, then read -> 'hDEADBE55.
- Read ADR='h0100 and write ADR=ID_ADR -> ERR_O high, ACK_O 0; a subsequent read of BASE_ADR+3 is unchanged.
- WAIT_STATES=3: read BASE_ADR -> ACK_O visible exactly 4 cycles after the STB_I rise; STB_I dropped after 2 cycles instead -> no ACK, state IDLE, RAM unchanged.
- Hold STB_I high 5 cycles after ACK on a write of 'h1 to BASE_ADR -> ACK_O stays high, a single commit; DAT_I changed to 'h2 meanwhile -> readback 'h1.
- RST_I pulsed during WAIT of a write -> ACK_O/ERR_O=0, DAT_O=0, target word keeps its old value; the next read completes normally.
